regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (wen/rd/dataD) between NUM_REQ writeback sources, e.g. ALU, load unit and CSR unit.
- Each source offers a write with a valid/ready handshake. The arbiter picks one per cycle, round-robin, and drives the write port from registered outputs.
- Writes to x0 are absorbed without consuming the port.
- Sits between the execute/memory stages and the register file.

Parameters:
NUM_REQ, 3, number of writeback requesters (2..8)
ADDR_WIDTH, 5, register index width
DATA_WIDTH, 64, register data width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
hold  input  1  freeze arbitration (e.g. debug halt)
req_valid  input  NUM_REQ  per-source write request
req_ready  output  NUM_REQ  per-source accept, combinational
req_rd  input  NUM_REQ*ADDR_WIDTH  destination index, source i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
req_data  input  NUM_REQ*DATA_WIDTH  write data, packed the same way
rf_wen  output  1  register-file write enable (registered)
rf_rd  output  ADDR_WIDTH  register-file write index (registered)
rf_data  output  DATA_WIDTH  register-file write data (registered)
rf_grant_id  output  $clog2(NUM_REQ)  index of source that produced the current rf_wen pulse
collision  output  1  registered pulse: two or more non-x0 requests competed in the previous cycle

Behaviour:
- Reset (async, any time, including mid-transfer):
  - rf_wen=0, rf_rd=0, rf_data=0, rf_grant_id=0, collision=0.
  - Round-robin pointer last=NUM_REQ-1, so source 0 has first priority.
  - In-flight grants are discarded.
  - req_ready is combinational from inputs and is 0 for every source while rst=1.
- Eligibility: source i is eligible when req_valid[i]=1 and its req_rd!=0.
- Grant:
  - When hold=0, scan i = last+1, last+2, ... (mod NUM_REQ). The first eligible source wins.
  - req_ready[win]=1 combinationally in the same cycle; the transfer completes that cycle.
- x0 absorb: when hold=0, any source with req_valid=1 and req_rd=0 sees req_ready=1 the same cycle. It never wins, never moves the pointer and never asserts rf_wen.
- Non-winning eligible sources see req_ready=0. They must hold valid/rd/data stable until accepted; the arbiter never drops them.
- Latency: a grant in cycle N produces rf_wen=1, rf_rd=req_rd[win], rf_data=req_data[win] and rf_grant_id=win in cycle N+1, for exactly one cycle per grant.
- No grant in a cycle: rf_wen=0 next cycle. rf_rd, rf_data and rf_grant_id hold their previous values.
- Pointer: on a grant, last<=win. Otherwise last is unchanged.
- Fairness: a continuously eligible source is granted within NUM_REQ cycles.
- collision: next cycle equals 1 when two or more sources were eligible and hold=0; otherwise 0.
- hold=1:
  - All req_ready=0, including x0 requests.
  - rf_wen<=0, last unchanged, collision<=0.
  - Arbitration resumes on the first cycle hold=0, using the unchanged pointer.
- Same rd from different sources: writes are issued in grant order, so the later grant wins in the register file. There is no merging.
- The block never asserts rf_wen with rf_rd=0.
- Back-to-back grants every cycle are supported; throughput is 1 write/cycle.

Test Plan:
- Reset, then source1 valid rd=5 data=0xAA for one cycle -> req_ready[1]=1 same cycle; next cycle rf_wen=1, rf_rd=5, rf_data=0xAA, rf_grant_id=1; cycle after, rf_wen=0.
- Sources 0, 1, 2 all valid continuously with rd=1, 2, 3 -> grants in order 0, 1, 2, 0, 1, 2...; rf_rd sequence 1, 2, 3, 1...; collision=1 from the second cycle while ≥2 eligible.
- Source0 rd=0 data=0x55 alongside source2 rd=7 -> both req_ready=1 the same cycle; next cycle rf_wen=1, rf_rd=7; no write to x0 ever appears; pointer=2.
- hold=1 for 3 cycles with sources 0 and 1 valid -> req_ready=0, rf_wen=0 throughout; after hold drops, source 0 is granted first (pointer was 2).
- Assert rst for one cycle while source2 is granted -> rf_wen=0 immediately (async); after release, with all sources valid, source 0 is granted first.
- Sources 0 and 1 both target rd=4 with data 0x1 and 0x2 -> two consecutive rf_wen pulses, rd=4 with 0x1, then rd=4 with 0x2.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing one register-file write port between NUM_REQ writeback sources.
// Writes to x0 are accepted and dropped without taking the port or moving the pointer.
module regfile_wb_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64,
  localparam int IDW       = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          hold,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_rd,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic                          rf_wen,
  output logic [ADDR_WIDTH-1:0]         rf_rd,
  output logic [DATA_WIDTH-1:0]         rf_data,
  output logic [IDW-1:0]                rf_grant_id,
  output logic                          collision
);

  logic [ADDR_WIDTH-1:0] rd_arr   [NUM_REQ];
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic [NUM_REQ-1:0]    eligible;
  logic [NUM_REQ-1:0]    absorb;

  logic [IDW-1:0]        last_q;
  logic                  rf_wen_q;
  logic [ADDR_WIDTH-1:0] rf_rd_q;
  logic [DATA_WIDTH-1:0] rf_data_q;
  logic [IDW-1:0]        rf_grant_id_q;
  logic                  collision_q;

  logic                  found;
  logic [IDW-1:0]        win;
  logic [IDW:0]          idx;
  logic                  grant_d;
  logic                  collision_d;

  always_comb begin
    eligible = '0;
    absorb   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rd_arr[i]   = req_rd[i*ADDR_WIDTH +: ADDR_WIDTH];
      data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      eligible[i] = req_valid[i] && (rd_arr[i] != '0);
      absorb[i]   = req_valid[i] && (rd_arr[i] == '0);
    end
  end

  // Scan starting just after the last winner; idx is one bit wider so the wrap needs no modulo.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = {1'b0, last_q} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(NUM_REQ)) idx = idx - (IDW+1)'(NUM_REQ);
      if (!found && eligible[idx[IDW-1:0]]) begin
        found = 1'b1;
        win   = idx[IDW-1:0];
      end
    end
  end

  assign grant_d     = !hold && found;
  assign collision_d = !hold && (|(eligible & (eligible - NUM_REQ'(1))));

  always_comb begin
    req_ready = '0;
    if (!rst && !hold) begin
      req_ready = absorb;
      if (found) req_ready[win] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q        <= IDW'(NUM_REQ - 1);
      rf_wen_q      <= 1'b0;
      rf_rd_q       <= '0;
      rf_data_q     <= '0;
      rf_grant_id_q <= '0;
      collision_q   <= 1'b0;
    end else begin
      rf_wen_q    <= grant_d;
      collision_q <= collision_d;
      if (grant_d) begin
        last_q        <= win;
        rf_rd_q       <= rd_arr[win];
        rf_data_q     <= data_arr[win];
        rf_grant_id_q <= win;
      end
    end
  end

  assign rf_wen      = rf_wen_q;
  assign rf_rd       = rf_rd_q;
  assign rf_data     = rf_data_q;
  assign rf_grant_id = rf_grant_id_q;
  assign collision   = collision_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scenario bench for regfile_wb_arbiter: tasks drive traffic and push expected writes,
// a negedge monitor pops them as rf_wen pulses appear.
module tb_regfile_wb_arbiter;
  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 64;

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
    logic [1:0]    id;
  } wr_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            hold = 1'b0;
  logic [N-1:0]    reqValid = '0;
  logic [N-1:0]    reqReady;
  logic [N*AW-1:0] reqRd = '0;
  logic [N*DW-1:0] reqData = '0;
  logic            rfWen;
  logic [AW-1:0]   rfRd;
  logic [DW-1:0]   rfData;
  logic [1:0]      rfGrantId;
  logic            collision;

  int compared = 0;
  int mismatched = 0;
  int expPtr = N - 1;
  wr_t expQ[$];

  regfile_wb_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .req_valid(reqValid), .req_ready(reqReady),
    .req_rd(reqRd), .req_data(reqData),
    .rf_wen(rfWen), .rf_rd(rfRd), .rf_data(rfData),
    .rf_grant_id(rfGrantId), .collision(collision)
  );

  always #5 clk = ~clk;

  // Every write pulse must match the oldest outstanding expectation and never target x0.
  always @(negedge clk) begin
    if (!rst && rfWen) begin
      wr_t e;
      compared++;
      if (expQ.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL unexpected_write: got rd=%0d data=%h id=%0d, required no write", rfRd, rfData, rfGrantId);
      end else begin
        e = expQ.pop_front();
        if (rfRd !== e.rd || rfData !== e.data || rfGrantId !== e.id || rfRd === '0) begin
          mismatched++;
          $display("[TB] FAIL write: got rd=%0d data=%h id=%0d, required rd=%0d data=%h id=%0d",
                   rfRd, rfData, rfGrantId, e.rd, e.data, e.id);
        end
      end
    end
  end

  task automatic setSrc(input int i, input logic v, input logic [AW-1:0] rd, input logic [DW-1:0] d);
    reqValid[i]          = v;
    reqRd[i*AW +: AW]    = rd;
    reqData[i*DW +: DW]  = d;
  endtask

  task automatic pushExp(input logic [AW-1:0] rd, input logic [DW-1:0] d, input int id);
    wr_t e;
    e.rd = rd; e.data = d; e.id = 2'(id);
    expQ.push_back(e);
  endtask

  task automatic nextCycle;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    setSrc(0, 1, 5'd1, 64'h1); setSrc(1, 1, 5'd2, 64'h2); setSrc(2, 1, 5'd0, 64'h3);
    @(negedge clk);
    compared++;
    if (rfWen !== 1'b0 || rfRd !== '0 || rfData !== '0 || rfGrantId !== '0 || collision !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got wen=%b rd=%0d data=%h id=%0d coll=%b, required all zero",
               rfWen, rfRd, rfData, rfGrantId, collision);
    end
    compared++;
    if (reqReady !== 3'b000) begin
      mismatched++;
      $display("[TB] FAIL reset_ready: got %b, required 000", reqReady);
    end
    reqValid = '0;
    nextCycle();
    rst = 1'b0;
    expPtr = N - 1;
  endtask

  task automatic test_single;
    nextCycle();
    setSrc(1, 1, 5'd5, 64'hAA);
    @(negedge clk);
    compared++;
    if (reqReady !== 3'b010) begin
      mismatched++;
      $display("[TB] FAIL single_ready: got %b, required 010", reqReady);
    end
    pushExp(5'd5, 64'hAA, 1);
    expPtr = 1;
    nextCycle();
    reqValid = '0;
    @(negedge clk);
    compared++;
    if (rfWen !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL single_wen: got %b, required 1", rfWen);
    end
    nextCycle();
    @(negedge clk);
    compared++;
    if (rfWen !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL single_wen_drop: got %b, required 0", rfWen);
    end
  endtask

  task automatic test_back_to_back;
    int w;
    nextCycle();
    for (int i = 0; i < N; i++) setSrc(i, 1, 5'(i + 1), 64'h100 + 64'(i));
    for (int c = 0; c < 6; c++) begin
      w = (expPtr + 1) % N;
      @(negedge clk);
      compared++;
      if (reqReady !== 3'(1 << w)) begin
        mismatched++;
        $display("[TB] FAIL rr_ready[%0d]: got %b, required %b", c, reqReady, 3'(1 << w));
      end
      compared++;
      if (collision !== (c != 0)) begin
        mismatched++;
        $display("[TB] FAIL rr_collision[%0d]: got %b, required %b", c, collision, (c != 0));
      end
      pushExp(5'(w + 1), 64'h100 + 64'(w), w);
      expPtr = w;
      nextCycle();
    end
    reqValid = '0;
    @(negedge clk);
    compared++;
    if (collision !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL rr_collision_tail: got %b, required 1", collision);
    end
    nextCycle();
    @(negedge clk);
    compared++;
    if (collision !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL rr_collision_clear: got %b, required 0", collision);
    end
  endtask

  task automatic test_x0;
    nextCycle();
    setSrc(0, 1, 5'd0, 64'h55);
    setSrc(2, 1, 5'd7, 64'h77);
    @(negedge clk);
    compared++;
    if (reqReady !== 3'b101) begin
      mismatched++;
      $display("[TB] FAIL x0_ready: got %b, required 101", reqReady);
    end
    pushExp(5'd7, 64'h77, 2);
    expPtr = 2;
    nextCycle();
    reqValid = '0;
    @(negedge clk);
    compared++;
    if (collision !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL x0_collision: got %b, required 0", collision);
    end
  endtask

  task automatic test_hold;
    nextCycle();
    hold = 1'b1;
    setSrc(0, 1, 5'd8, 64'h88);
    setSrc(1, 1, 5'd9, 64'h99);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      compared++;
      if (reqReady !== 3'b000 || rfWen !== 1'b0 || collision !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL hold[%0d]: got ready=%b wen=%b coll=%b, required 000/0/0", c, reqReady, rfWen, collision);
      end
      nextCycle();
    end
    hold = 1'b0;
    @(negedge clk);
    compared++;
    if (reqReady !== 3'b001) begin
      mismatched++;
      $display("[TB] FAIL hold_resume: got %b, required 001", reqReady);
    end
    pushExp(5'd8, 64'h88, 0);
    nextCycle();
    reqValid[0] = 1'b0;
    @(negedge clk);
    compared++;
    if (reqReady !== 3'b010 || collision !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL hold_second: got ready=%b coll=%b, required 010/1", reqReady, collision);
    end
    pushExp(5'd9, 64'h99, 1);
    expPtr = 1;
    nextCycle();
    reqValid = '0;
  endtask

  task automatic test_same_rd;
    nextCycle();
    setSrc(0, 1, 5'd4, 64'h1);
    setSrc(1, 1, 5'd4, 64'h2);
    @(negedge clk);
    compared++;
    if (reqReady !== 3'b001) begin
      mismatched++;
      $display("[TB] FAIL same_rd_first: got %b, required 001", reqReady);
    end
    pushExp(5'd4, 64'h1, 0);
    nextCycle();
    reqValid[0] = 1'b0;
    @(negedge clk);
    compared++;
    if (reqReady !== 3'b010) begin
      mismatched++;
      $display("[TB] FAIL same_rd_second: got %b, required 010", reqReady);
    end
    pushExp(5'd4, 64'h2, 1);
    expPtr = 1;
    nextCycle();
    reqValid = '0;
  endtask

  task automatic test_reset_mid;
    nextCycle();
    for (int i = 0; i < N; i++) setSrc(i, 1, 5'(i + 1), 64'h200 + 64'(i));
    @(negedge clk);
    compared++;
    if (reqReady !== 3'b100) begin
      mismatched++;
      $display("[TB] FAIL mid_ready: got %b, required 100", reqReady);
    end
    pushExp(5'd3, 64'h202, 2);
    nextCycle();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    compared++;
    if (rfWen !== 1'b0 || rfRd !== '0 || rfData !== '0 || rfGrantId !== '0 || reqReady !== 3'b000) begin
      mismatched++;
      $display("[TB] FAIL mid_async_reset: got wen=%b rd=%0d data=%h id=%0d ready=%b, required zeros",
               rfWen, rfRd, rfData, rfGrantId, reqReady);
    end
    nextCycle();
    rst = 1'b0;
    @(negedge clk);
    compared++;
    if (reqReady !== 3'b001) begin
      mismatched++;
      $display("[TB] FAIL mid_restart: got %b, required 001", reqReady);
    end
    pushExp(5'd1, 64'h200, 0);
    expPtr = 0;
    nextCycle();
    reqValid = '0;
    @(negedge clk);
    nextCycle();
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_single();
    test_back_to_back();
    test_x0();
    test_hold();
    test_same_rd();
    test_reset_mid();
    repeat (2) nextCycle();
    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL missing_writes: got %0d outstanding, required 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #20000;
    $display("[TB] FAIL timeout: got no finish, required finish before 20000");
    $fatal(1, "[TB] timeout");
  end
endmodule
